// File: rtl/bmc_subframe_encoder.sv
// S/PDIF subframe builder + biphase-mark line coder; dout moves on the clk edge carrying cell_tick.
// One-entry holding register: in_ready = !hold_full, freed only at the subframe-start tick.
module bmc_subframe_encoder #(
  parameter int FRAMES_PER_BLOCK = 192,
  parameter int CS_BITS          = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cell_tick,
  input  logic [19:0] din,
  input  logic [3:0]  aux,
  input  logic        validity,
  input  logic        user,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] cs_word,
  output logic        dout,
  output logic        channel,
  output logic [7:0]  frame_counter,
  output logic        subframe_start,
  output logic        underrun
);

  localparam logic [7:0] PRE_B      = 8'b11101000;
  localparam logic [7:0] PRE_M      = 8'b11100010;
  localparam logic [7:0] PRE_W      = 8'b11100100;
  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);
  localparam logic [7:0] CS_LIMIT   = 8'(CS_BITS);

  logic [5:0]  cell_cnt;
  logic        hold_full;
  logic [19:0] hold_din;
  logic [3:0]  hold_aux;
  logic        hold_v;
  logic        hold_u;
  logic [27:0] slot_sr;
  logic        pre_inv;

  logic        accept;
  logic        sf_begin;
  logic        c_bit;
  logic [26:0] body;
  logic [7:0]  preamble;
  logic [2:0]  pre_idx;
  logic        pre_level;

  assign in_ready = !hold_full;
  assign accept   = in_valid && !hold_full;
  assign sf_begin = cell_tick && (cell_cnt == 6'd0);

  always_comb begin
    c_bit = 1'b0;
    if (frame_counter < CS_LIMIT) c_bit = cs_word[frame_counter[4:0]];
    // Slots 30..4 packed LSB-first; an empty holding register sends a flagged-invalid silent sample.
    body = hold_full ? {c_bit, hold_u, hold_v, hold_din, hold_aux}
                     : {c_bit, 1'b0, 1'b1, 20'd0, 4'd0};
    preamble  = channel ? PRE_W : ((frame_counter == 8'd0) ? PRE_B : PRE_M);
    pre_idx   = 3'd7 - cell_cnt[2:0];
    pre_level = preamble[pre_idx] ^ ((cell_cnt == 6'd0) ? dout : pre_inv);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cell_cnt       <= 6'd0;
      hold_full      <= 1'b0;
      hold_din       <= 20'd0;
      hold_aux       <= 4'd0;
      hold_v         <= 1'b0;
      hold_u         <= 1'b0;
      slot_sr        <= 28'd0;
      pre_inv        <= 1'b0;
      dout           <= 1'b0;
      channel        <= 1'b0;
      frame_counter  <= 8'd0;
      subframe_start <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      // A sample accepted on the start edge can only arrive into an empty register and is kept.
      if (accept) begin
        hold_full <= 1'b1;
        hold_din  <= din;
        hold_aux  <= aux;
        hold_v    <= validity;
        hold_u    <= user;
      end else if (sf_begin) begin
        hold_full <= 1'b0;
      end

      subframe_start <= sf_begin;
      underrun       <= sf_begin && !hold_full;

      if (cell_tick) begin
        cell_cnt <= cell_cnt + 6'd1;
        if (cell_cnt < 6'd8) begin
          dout <= pre_level;
          if (sf_begin) begin
            slot_sr <= {^body, body};
            pre_inv <= dout;
          end
        end else if (!cell_cnt[0]) begin
          dout <= ~dout;
        end else begin
          dout    <= dout ^ slot_sr[0];
          slot_sr <= slot_sr >> 1;
        end

        if (cell_cnt == 6'd63) begin
          channel <= ~channel;
          if (channel)
            frame_counter <= (frame_counter == LAST_FRAME) ? 8'd0 : frame_counter + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmc_subframe_encoder.sv
// Bench for bmc_subframe_encoder: random samples, queue-based reference of the subframe stream.
module tb_bmc_subframe_encoder;

  typedef struct packed {
    logic        u;
    logic        v;
    logic [3:0]  aux;
    logic [19:0] din;
  } smp_t;

  localparam logic [7:0] PB = 8'b11101000;
  localparam logic [7:0] PM = 8'b11100010;
  localparam logic [7:0] PW = 8'b11100100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cell_tick = 1'b0;
  logic [19:0] din = '0;
  logic [3:0]  aux = '0;
  logic        validity = 1'b0;
  logic        user = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] cs_word = '0;
  logic        dout;
  logic        channel;
  logic [7:0]  frame_counter;
  logic        subframe_start;
  logic        underrun;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bmc_subframe_encoder dut (
    .clk(clk), .rst(rst), .cell_tick(cell_tick), .din(din), .aux(aux),
    .validity(validity), .user(user), .in_valid(in_valid), .in_ready(in_ready),
    .cs_word(cs_word), .dout(dout), .channel(channel), .frame_counter(frame_counter),
    .subframe_start(subframe_start), .underrun(underrun)
  );

  // Reference state: accepted samples wait in a queue until a subframe claims them.
  smp_t        q[$];
  smp_t        cur_s, fix_s, last_acc;
  bit          feed_en = 0, fixed_en = 0, need_new = 1;
  int          m_cell = 0, m_fc = 0;
  logic        m_ch = 1'b0, m_lvl = 1'b0;
  logic [63:0] exp_cells = '0, obs_cells = '0;
  int          und_cnt = 0, sfs_cnt = 0, rdy_hi_cnt = 0, und_total = 0;

  function automatic logic [31:0] slot_bits(input smp_t s, input logic c);
    logic [31:0] b;
    b = '0;
    b[7:4]  = s.aux;
    b[27:8] = s.din;
    b[28]   = s.v;
    b[29]   = s.u;
    b[30]   = c;
    b[31]   = ($countones(b) % 2) == 1;
    return b;
  endfunction

  function automatic logic [63:0] bmc(input logic [7:0] pre, input logic [31:0] b, input logic lvl0);
    logic [63:0] c;
    logic        l;
    c = '0;
    for (int i = 0; i < 8; i++) c[i] = pre[7-i] ^ lvl0;
    l = c[7];
    for (int s = 4; s < 32; s++) begin
      l = ~l;
      c[2*s] = l;
      if (b[s]) l = ~l;
      c[2*s+1] = l;
    end
    return c;
  endfunction

  function automatic logic [31:0] dec_all(input logic [63:0] c);
    logic [31:0] r;
    r = '0;
    for (int s = 4; s < 32; s++) r[s] = c[2*s] ^ c[2*s+1];
    return r;
  endfunction

  function automatic logic [7:0] pre_of(input logic [63:0] c);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[7-i] = c[i];
    return p;
  endfunction

  task automatic step(input bit tick, input bit do_rst);
    bit          acc;
    int          cidx;
    smp_t        s;
    logic        cb;
    logic [7:0]  pre;
    @(negedge clk);
    if (need_new) begin
      cur_s    = fixed_en ? fix_s : smp_t'(26'($urandom));
      need_new = 0;
    end
    {user, validity, aux, din} = cur_s;
    in_valid  = feed_en;
    cell_tick = tick;
    rst       = do_rst;
    acc  = feed_en && (q.size() == 0) && !do_rst;
    cidx = m_cell;
    @(posedge clk);
    if (do_rst) begin
      q.delete();
      m_cell = 0; m_ch = 1'b0; m_fc = 0; m_lvl = 1'b0;
    end else begin
      if (tick && m_cell == 0) begin
        if (q.size() > 0) s = q.pop_front();
        else begin
          s   = smp_t'(26'd0);
          s.v = 1'b1;
        end
        cb  = (m_fc < 32) ? cs_word[m_fc] : 1'b0;
        pre = m_ch ? PW : ((m_fc == 0) ? PB : PM);
        exp_cells  = bmc(pre, slot_bits(s, cb), m_lvl);
        obs_cells  = '0;
        und_cnt    = 0;
        sfs_cnt    = 0;
        rdy_hi_cnt = 0;
      end
      if (acc) begin
        q.push_back(cur_s);
        last_acc = cur_s;
        need_new = 1;
      end
      if (tick) begin
        m_lvl = exp_cells[m_cell];
        m_cell++;
        if (m_cell == 64) begin
          m_cell = 0;
          m_ch   = ~m_ch;
          if (!m_ch) m_fc = (m_fc == 191) ? 0 : m_fc + 1;
        end
      end
    end
    #1;
    if (!do_rst) begin
      if (tick) obs_cells[cidx] = dout;
      und_cnt    += int'(underrun);
      und_total  += int'(underrun);
      sfs_cnt    += int'(subframe_start);
      rdy_hi_cnt += int'(in_ready);
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) step(0, 0);
      step(1, 0);
    end
  endtask

  task automatic run_subframe;
    run_ticks(64);
  endtask

  task automatic do_reset;
    step(0, 1);
    step(0, 1);
    need_new  = 1;
    und_total = 0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    feed_en = 0;
    do_reset();
    checks++; if (dout !== 1'b0) begin fails++; $display("FAIL reset_dout: got %b want 0", dout); end
    checks++; if (channel !== 1'b0) begin fails++; $display("FAIL reset_channel: got %b want 0", channel); end
    checks++; if (frame_counter !== 8'd0) begin fails++; $display("FAIL reset_frame_counter: got %0d want 0", frame_counter); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (subframe_start !== 1'b0 || underrun !== 1'b0) begin fails++; $display("FAIL reset_pulses: got sfs=%b und=%b want 0/0", subframe_start, underrun); end
    run_subframe();
    d = dec_all(obs_cells);
    checks++; if (pre_of(obs_cells) !== PB) begin fails++; $display("FAIL idle_preamble: got %b want %b", pre_of(obs_cells), PB); end
    checks++; if (und_cnt != 1) begin fails++; $display("FAIL idle_underrun_count: got %0d want 1", und_cnt); end
    checks++; if (sfs_cnt != 1) begin fails++; $display("FAIL idle_start_count: got %0d want 1", sfs_cnt); end
    checks++; if (d[31:4] !== 28'h9000000) begin fails++; $display("FAIL idle_slots: got %h want 9000000", d[31:4]); end
    checks++; if (obs_cells !== exp_cells) begin fails++; $display("FAIL idle_cells: got %h want %h", obs_cells, exp_cells); end
  endtask

  task automatic test_stream;
    logic [7:0]  pre_tab[4];
    logic        c_tab[4];
    logic [31:0] d;
    pre_tab = '{PB, PW, PM, PW};
    c_tab   = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    cs_word  = 32'd1;
    fix_s    = '{u: 1'b0, v: 1'b0, aux: 4'h5, din: 20'hAAAAA};
    fixed_en = 1;
    need_new = 1;
    feed_en  = 1;
    step(0, 0);
    for (int k = 0; k < 4; k++) begin
      run_subframe();
      d = dec_all(obs_cells);
      checks++; if (pre_of(obs_cells) !== pre_tab[k]) begin fails++; $display("FAIL stream_preamble[%0d]: got %b want %b", k, pre_of(obs_cells), pre_tab[k]); end
      checks++; if (d[27:8] !== 20'hAAAAA || d[7:4] !== 4'h5) begin fails++; $display("FAIL stream_audio[%0d]: got %h/%h want AAAAA/5", k, d[27:8], d[7:4]); end
      checks++; if (d[30] !== c_tab[k]) begin fails++; $display("FAIL stream_cbit[%0d]: got %b want %b", k, d[30], c_tab[k]); end
      checks++; if ($countones(d[31:4]) % 2 != 0) begin fails++; $display("FAIL stream_parity[%0d]: got %0d ones want even", k, $countones(d[31:4])); end
      checks++; if (und_cnt != 0) begin fails++; $display("FAIL stream_underrun[%0d]: got %0d want 0", k, und_cnt); end
      checks++; if (obs_cells !== exp_cells) begin fails++; $display("FAIL stream_cells[%0d]: got %h want %h", k, obs_cells, exp_cells); end
    end
    fixed_en = 0;
    need_new = 1;
  endtask

  task automatic test_block_wrap;
    int nb, mism;
    nb = 0; mism = 0;
    do_reset();
    cs_word = $urandom;
    feed_en = 1;
    step(0, 0);
    for (int f = 0; f < 193; f++) begin
      for (int ch = 0; ch < 2; ch++) begin
        run_subframe();
        if (pre_of(obs_cells) === PB) nb++;
        if (obs_cells !== exp_cells) mism++;
        if (f == 190 && ch == 1) begin
          checks++; if (frame_counter !== 8'd191) begin fails++; $display("FAIL block_last_frame: got %0d want 191", frame_counter); end
        end
        if (f == 191 && ch == 1) begin
          checks++; if (frame_counter !== 8'd0 || channel !== 1'b0) begin fails++; $display("FAIL block_wrap: got fc=%0d ch=%b want 0/0", frame_counter, channel); end
        end
      end
    end
    checks++; if (nb != 2) begin fails++; $display("FAIL block_b_count: got %0d want 2", nb); end
    checks++; if (mism != 0) begin fails++; $display("FAIL block_cells: got %0d bad subframes want 0", mism); end
    checks++; if (und_total != 0) begin fails++; $display("FAIL block_underrun: got %0d want 0", und_total); end
  endtask

  task automatic test_back_to_back;
    smp_t        a1, x;
    logic [31:0] d;
    do_reset();
    feed_en = 1;
    step(0, 0);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hs_ready_after_accept: got %b want 0", in_ready); end
    step(0, 0);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hs_ready_holds_low: got %b want 0", in_ready); end
    step(1, 0);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hs_ready_at_start: got %b want 1", in_ready); end
    step(1, 0);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hs_ready_refill: got %b want 0", in_ready); end
    a1 = last_acc;
    run_ticks(62);
    checks++; if (rdy_hi_cnt != 1) begin fails++; $display("FAIL hs_ready_high_cycles: got %0d want 1", rdy_hi_cnt); end
    checks++; if (obs_cells !== exp_cells || und_cnt != 0) begin fails++; $display("FAIL hs_sf0: got und=%0d cells %h want 0 / %h", und_cnt, obs_cells, exp_cells); end
    feed_en = 0;
    run_subframe();
    d = dec_all(obs_cells);
    checks++; if (d[27:8] !== a1.din || und_cnt != 0) begin fails++; $display("FAIL hs_refill_sample: got %h und=%0d want %h und=0", d[27:8], und_cnt, a1.din); end
    // Present a sample only on the edge that starts an empty-register subframe.
    x        = smp_t'(26'($urandom));
    cur_s    = x;
    need_new = 0;
    feed_en  = 1;
    step(1, 0);
    feed_en  = 0;
    run_ticks(63);
    checks++; if (und_cnt != 1 || obs_cells !== exp_cells) begin fails++; $display("FAIL hs_edge_underrun: got und=%0d cells %h want 1 / %h", und_cnt, obs_cells, exp_cells); end
    run_subframe();
    d = dec_all(obs_cells);
    checks++; if (d[27:8] !== x.din || d[28] !== x.v || und_cnt != 0) begin fails++; $display("FAIL hs_edge_sample: got din=%h v=%b und=%0d want %h/%b/0", d[27:8], d[28], und_cnt, x.din, x.v); end
    run_subframe();
    d = dec_all(obs_cells);
    checks++; if (d[27:8] !== 20'd0 || und_cnt != 1) begin fails++; $display("FAIL hs_no_duplicate: got din=%h und=%0d want 0/1", d[27:8], und_cnt); end
  endtask

  task automatic test_underrun;
    smp_t        resume;
    logic [31:0] d;
    int          bad_pol;
    bad_pol = 0;
    do_reset();
    feed_en = 1;
    step(0, 0);
    run_subframe();
    feed_en = 0;
    run_subframe();
    checks++; if (und_cnt != 0) begin fails++; $display("FAIL ur_last_held: got %0d want 0", und_cnt); end
    if (obs_cells[0] !== 1'b1) bad_pol++;
    feed_en = 1;
    run_subframe();
    resume = q[0];
    d = dec_all(obs_cells);
    if (obs_cells[0] !== 1'b1) bad_pol++;
    checks++; if (und_cnt != 1) begin fails++; $display("FAIL ur_pulse: got %0d want 1", und_cnt); end
    checks++; if (d[28] !== 1'b1 || d[27:4] !== 24'd0) begin fails++; $display("FAIL ur_content: got v=%b audio=%h want 1/0", d[28], d[27:4]); end
    checks++; if (obs_cells !== exp_cells) begin fails++; $display("FAIL ur_cells: got %h want %h", obs_cells, exp_cells); end
    run_subframe();
    d = dec_all(obs_cells);
    if (obs_cells[0] !== 1'b1) bad_pol++;
    checks++; if (d[27:8] !== resume.din || und_cnt != 0) begin fails++; $display("FAIL ur_resume: got %h und=%0d want %h und=0", d[27:8], und_cnt, resume.din); end
    checks++; if (bad_pol != 0) begin fails++; $display("FAIL ur_polarity: got %0d inverted preambles want 0", bad_pol); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    feed_en = 1;
    step(0, 0);
    run_subframe();
    run_ticks(37);
    checks++; if (channel !== 1'b1) begin fails++; $display("FAIL mr_pre_channel: got %b want 1", channel); end
    feed_en = 0;
    step(1, 1);
    checks++; if (dout !== 1'b0 || channel !== 1'b0 || frame_counter !== 8'd0) begin fails++; $display("FAIL mr_state: got dout=%b ch=%b fc=%0d want 0/0/0", dout, channel, frame_counter); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mr_in_ready: got %b want 1", in_ready); end
    run_subframe();
    checks++; if (pre_of(obs_cells) !== PB) begin fails++; $display("FAIL mr_preamble: got %b want %b", pre_of(obs_cells), PB); end
    checks++; if (und_cnt != 1 || obs_cells !== exp_cells) begin fails++; $display("FAIL mr_dropped: got und=%0d cells %h want 1 / %h", und_cnt, obs_cells, exp_cells); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_underrun();
    test_mid_reset();
    test_block_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
